// File: rtl/cpu_port_bridge_pkg.sv
// Shared defaults and FSM encoding for the CPU I/O port bridge.
package cpu_port_bridge_pkg;

    localparam int unsigned WIDTH_DEF    = 16;
    localparam int unsigned DEPTH_DEF    = 8;
    localparam int unsigned IN_RESET_DEF = 3;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/cpu_port_bridge_sync_fifo.sv
// Synchronous FIFO with exact occupancy count; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module cpu_port_bridge_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == LW'(0));
    assign w_pop   = i_pop & ~w_empty;
    assign w_push  = i_push & (~w_full | w_pop);

    // When full, wr_ptr == rd_ptr: a push+pop overwrites the departing head slot.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule

// File: rtl/cpu_port_bridge.sv
// Host-side endpoint for the CPU I/O ports: drives cpu_in from a write stream
// and reports every change on cpu_out through a read FIFO.
module cpu_port_bridge
    import cpu_port_bridge_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned IN_RESET = IN_RESET_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       cpu_out,
    output logic [WIDTH-1:0]       cpu_in,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    state_t           r_state;
    logic [WIDTH-1:0] r_cpu_in;
    logic [WIDTH-1:0] r_base;
    logic             r_wr_ready;
    logic             r_ovf;

    logic             w_change;
    logic             w_full;
    logic             w_empty;
    logic             w_ovf_set;

    assign w_change  = (r_state == ST_RUN) && (cpu_out != r_base);
    // A full FIFO is never empty, so a pop happens exactly when rd_ready is high.
    assign w_ovf_set = w_change & w_full & ~rd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_PRIME;
            r_cpu_in   <= WIDTH'(IN_RESET);
            r_base     <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            if (r_state == ST_PRIME) begin
                // Swallow the CPU's own reset value of 'out' as the baseline.
                r_base     <= cpu_out;
                r_wr_ready <= 1'b0;
                r_state    <= ST_RUN;
            end else begin
                r_wr_ready <= 1'b1;
                r_state    <= ST_RUN;
                if (w_change) begin
                    r_base <= cpu_out;
                end
                if (wr_valid && r_wr_ready) begin
                    r_cpu_in <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    cpu_port_bridge_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_change),
        .i_data  (cpu_out),
        .i_pop   (rd_ready),
        .o_data  (rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign cpu_in   = r_cpu_in;
    assign wr_ready = r_wr_ready;
    assign rd_valid = ~w_empty;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_cpu_port_bridge.sv
// Randomized and directed bench for cpu_port_bridge against a queue-based reference model.
module tb_cpu_port_bridge;

    localparam int unsigned W = 16;
    localparam int unsigned D = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  cpu_out;
    logic [W-1:0]  cpu_in;
    logic [W-1:0]  wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [3:0]    level;
    logic          overflow;
    logic          ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;

    bit            m_run;
    bit            m_wrr;
    bit            m_ovf;
    logic [W-1:0]  m_cpu_in;
    logic [W-1:0]  m_base;
    logic [W-1:0]  m_q[$];
    int            m_peak;

    always #5 clk = ~clk;

    cpu_port_bridge dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_out  (cpu_out),
        .cpu_in   (cpu_in),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_cpu_in"},   32'(cpu_in),   32'(m_cpu_in));
        chk({pfx, "_wr_ready"}, 32'(wr_ready), 32'(m_wrr));
        chk({pfx, "_rd_valid"}, 32'(rd_valid), 32'(m_q.size() > 0));
        chk({pfx, "_level"},    32'(level),    32'(m_q.size()));
        chk({pfx, "_overflow"}, 32'(overflow), 32'(m_ovf));
        if (m_q.size() > 0) chk({pfx, "_rd_data"}, 32'(rd_data), 32'(m_q[0]));
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_wrr    = 1'b0;
        m_ovf    = 1'b0;
        m_cpu_in = W'(3);
        m_base   = '0;
        m_q.delete();
    endtask

    // Advance one clock: predict from pre-edge inputs, then compare after the edge.
    task automatic tick(input string pfx);
        bit was_run = m_run;
        bit do_pop  = rd_ready && (m_q.size() > 0);
        bit do_push = 1'b0;
        bit set_ovf = 1'b0;
        logic [W-1:0] val = cpu_out;
        if (!was_run) begin
            m_base = cpu_out;
            m_run  = 1'b1;
        end else begin
            if (wr_valid && m_wrr) m_cpu_in = wr_data;
            if (cpu_out != m_base) begin
                m_base = cpu_out;
                if (m_q.size() == D && !do_pop) set_ovf = 1'b1;
                else do_push = 1'b1;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(val);
        if (set_ovf) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_wrr = was_run;
        if (m_q.size() > m_peak) m_peak = m_q.size();
        @(posedge clk);
        #1;
        check_all(pfx);
    endtask

    // Assert reset mid-cycle (asynchronously), hold two edges, release at a falling edge.
    task automatic do_reset(input string pfx);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all({pfx, "_async"});
        wr_valid = 1'b0;
        ovf_clr  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all({pfx, "_hold"});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp2 [3];
        logic [W-1:0] vals [5];
        int rd_pct;
        exp2[0] = 16'h1234; exp2[1] = 16'hBEEF; exp2[2] = 16'h1234;
        vals[0] = 16'h0000; vals[1] = 16'h0001; vals[2] = 16'h0002;
        vals[3] = 16'h0003; vals[4] = 16'hABCD;

        reset    = 1'b1;
        cpu_out  = '0;
        wr_data  = '0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        m_peak   = 0;
        model_reset();
        @(negedge clk);

        // 1: reset state, wr_ready rises only after the second edge past release
        do_reset("t1");
        tick("t1_e1");
        chk("t1_wrr_edge1", 32'(wr_ready), 32'd0);
        tick("t1_e2");
        chk("t1_wrr_edge2", 32'(wr_ready), 32'd1);
        chk("t1_cpu_in", 32'(cpu_in), 32'h3);

        // 2: change detection A,A,B,A
        m_peak = 0;
        cpu_out = 16'h1234; tick("t2");
        cpu_out = 16'h1234; tick("t2");
        cpu_out = 16'hBEEF; tick("t2");
        cpu_out = 16'h1234; tick("t2");
        chk("t2_peak", 32'(level), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_order", 32'(rd_data), 32'(exp2[i]));
            rd_ready = 1'b1; tick("t2_rd"); rd_ready = 1'b0;
        end
        chk("t2_empty", 32'(rd_valid), 32'd0);

        // 3: single write
        wr_data = 16'h00A5; wr_valid = 1'b1; tick("t3");
        wr_valid = 1'b0; wr_data = 16'hFFFF;
        chk("t3_cpu_in", 32'(cpu_in), 32'h00A5);
        tick("t3"); tick("t3");
        chk("t3_hold", 32'(cpu_in), 32'h00A5);

        // 4: overflow with 9 changes, clear, then drain the first 8
        for (int i = 0; i < 9; i++) begin
            cpu_out = W'(16'h4000 + i); tick("t4");
        end
        chk("t4_level", 32'(level), 32'd8);
        chk("t4_ovf", 32'(overflow), 32'd1);
        ovf_clr = 1'b1; tick("t4_clr"); ovf_clr = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_rd", 32'(rd_data), 32'(16'h4000 + i));
            tick("t4_rd");
        end
        rd_ready = 1'b0;

        // 5: full FIFO, push+pop same edge
        for (int i = 0; i < 8; i++) begin
            cpu_out = W'(16'h5000 + i); tick("t5");
        end
        cpu_out = 16'h5555; rd_ready = 1'b1; tick("t5_pp"); rd_ready = 1'b0;
        chk("t5_level", 32'(level), 32'd8);
        chk("t5_ovf", 32'(overflow), 32'd0);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t5_rd", 32'(rd_data), (i == 7) ? 32'h5555 : 32'(16'h5001 + i));
            tick("t5_rd");
        end
        rd_ready = 1'b0;

        // 6: async reset with 5 entries, new cpu_out value at release is not reported
        for (int i = 0; i < 5; i++) begin
            cpu_out = W'(16'h6000 + i); tick("t6");
        end
        chk("t6_level5", 32'(level), 32'd5);
        cpu_out = 16'h7777;
        do_reset("t6");
        chk("t6_level0", 32'(level), 32'd0);
        tick("t6_post"); tick("t6_post"); tick("t6_post");
        chk("t6_nopush", 32'(rd_valid), 32'd0);

        // Random traffic with varying drain rate so the FIFO both fills and empties
        for (int c = 0; c < 3000; c++) begin
            rd_pct = ((c / 300) % 3 == 0) ? 10 : (((c / 300) % 3 == 1) ? 50 : 90);
            if ($urandom_range(99) < 50) cpu_out = vals[$urandom_range(4)];
            rd_ready = ($urandom_range(99) < rd_pct);
            wr_valid = $urandom_range(1);
            wr_data  = W'($urandom);
            ovf_clr  = ($urandom_range(99) < 5);
            tick("rnd");
            if ($urandom_range(999) < 3) do_reset("rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
